led_blink_ctrl: RTL
===================

LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter TICK_DIV, default 100000, SHALL set the clk cycles per blink tick (1 ms at 100 MHz); legal range 2..2^24.
REQ-003 Parameter N_LED, default 4, SHALL set the number of channels; fixed at 4 for this revision.
REQ-004 Port clk, input, 1, SHALL be the system clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port cs, input, 1, SHALL be the slot chip select.
REQ-007 Port read, input, 1, SHALL be the read strobe; informational only, reads have no side effects.
REQ-008 Port write, input, 1, SHALL be the write strobe; a write occurs when cs and write are both 1.
REQ-009 Port addr, input, 5, SHALL be the register word address.
REQ-010 Port wr_data, input, 32, SHALL be the write data.
REQ-011 Port rd_data, output, 32, SHALL be the read data, a combinational function of addr and the current register state.
REQ-012 Port led, output, 4, SHALL be the blinking LED drive, registered.

Function
REQ-013 The register map SHALL be: addr 0 CTRL, where bits[3:0] form the channel enable mask and all other bits read 0. Addr 1..4 SHALL be PERIOD0..PERIOD3, with bits[15:0] holding the half-period in ticks. Addr 5 STATUS SHALL be read-only, returning bits[3:0] = led and bits[7:4] = the enable mask. Any other addr SHALL read 0 and ignore writes.
REQ-014 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0. It SHALL assert an internal one-cycle tick in the cycle its count equals TICK_DIV-1.
REQ-015 Each channel SHALL hold a 16-bit counter cnt.
REQ-016 On tick, an enabled channel with PERIOD != 0 SHALL set cnt to 0 and toggle its led if cnt == PERIOD-1; otherwise it SHALL increment cnt.
REQ-017 Each LED SHALL therefore toggle every PERIOD ticks, giving a full blink cycle of 2*PERIOD ticks.
REQ-018 A channel with enable 0 SHALL hold cnt=0 and led=0 every cycle.
REQ-019 A channel with PERIOD == 0 SHALL hold cnt=0 and led=0, i.e. it is stopped, regardless of its enable bit.
REQ-020 A write to PERIODn SHALL take effect on the next clock edge. The same edge SHALL clear cnt of channel n to 0 and SHALL leave led unchanged.
REQ-021 When a PERIODn write coincides with a tick, the write SHALL win: cnt becomes 0 and led does not toggle on that edge.
REQ-022 A write to CTRL that changes an enable bit from 0 to 1 SHALL start that channel with cnt=0 and led=0. The first toggle SHALL occur on the PERIOD-th subsequent tick.
REQ-023 A write to CTRL SHALL NOT reset the prescaler, so the first interval after enable is between PERIOD-1 and PERIOD ticks.
REQ-024 Counter comparisons SHALL use 16-bit unsigned arithmetic. The value PERIOD = 0xFFFF SHALL be legal and SHALL not overflow cnt.
REQ-025 Read data SHALL reflect register and LED state as of the last clock edge, with no read side effects.

Reset
REQ-026 While rst = 0, all of the following SHALL be 0 asynchronously: the prescaler count, tick, all cnt, led, the CTRL enable mask, and PERIOD0..3.
REQ-027 Reset asserted mid-count SHALL abort all channels with no residual toggles.
REQ-028 After rst deasserts, the block SHALL be idle (led = 0) until software writes PERIOD and CTRL.

Structure
REQ-029 Package led_blink_pkg SHALL hold the following definitions:
- register address constants ADDR_CTRL = 0, ADDR_PERIOD0 = 1, ADDR_STATUS = 5;
- typedef period_t as logic[15:0];
- constant N_LED = 4.
REQ-030 Sub-module blink_channel SHALL implement one channel and SHALL be instantiated 4 times. Its ports SHALL be clk, rst, tick, en, period, load, and led.
REQ-031 The prescaler, the register file, and the read mux SHALL reside in led_blink_ctrl.

Verification (TICK_DIV = 4)
REQ-032 Bench: reset, then read addr 0..5 -> all 0, and led = 0.
REQ-033 Bench: write PERIOD0 = 3 and CTRL = 0x1 -> led[0] toggles every 12 clk after the first toggle, and led[3:1] stay 0.
REQ-034 Bench: run with PERIOD1 = 2 and CTRL = 0x2, then write PERIOD1 = 5 on a tick cycle -> no toggle on that edge, and the next toggle occurs 5 ticks later.
REQ-035 Bench: write CTRL = 0x0 while led = 0xF -> led = 0x0 on the next edge, and STATUS reads 0x00.
REQ-036 Bench: write CTRL = 0xF with PERIOD2 = 0 -> led[2] stays 0, the other channels blink, and STATUS[7:4] = 0xF.
REQ-037 Bench: assert rst low mid-count -> led = 0 immediately without waiting for clk, and all registers read 0 after release.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared register addresses and types for the LED blink controller.
package led_blink_pkg;

    localparam logic [4:0] ADDR_CTRL    = 5'd0;
    localparam logic [4:0] ADDR_PERIOD0 = 5'd1;
    localparam logic [4:0] ADDR_STATUS  = 5'd5;

    localparam int N_LED = 4;

    typedef logic [15:0] period_t;

endpackage

// File: rtl/led_blink_if.sv
// Register-slot bus between a host and the LED blink controller.
interface led_blink_if;

    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);

endinterface

// File: rtl/blink_channel.sv
// One LED channel: counts blink ticks and toggles its LED every PERIOD ticks.
module blink_channel
    import led_blink_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    tick,
    input  logic    en,
    input  period_t period,
    input  logic    load,
    output logic    led
);

    period_t cnt;

    // A stopped channel (disabled or zero period) is forced dark; a load
    // restarts the count without touching the LED and beats a coincident tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            led <= 1'b0;
        end else if (!en || period == '0) begin
            cnt <= '0;
            led <= 1'b0;
        end else if (load) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == period - 16'd1) begin
                cnt <= '0;
                led <= ~led;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// LED blink controller: prescaler, register file, read mux and four blink channels.
module led_blink_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int N_LED    = 4
) (
    input  logic             clk,
    input  logic             rst,
    led_blink_if.slave       bus,
    output logic [N_LED-1:0] led
);

    import led_blink_pkg::*;

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic             wr_en;
    logic [N_LED-1:0] en_mask;
    logic [N_LED-1:0] en_next;
    logic [N_LED-1:0] period_wr;
    logic [N_LED-1:0] load;
    period_t          period [N_LED];
    logic             unused_bits;

    assign wr_en       = bus.cs && bus.write;
    assign tick        = (pre_cnt == PW'(TICK_DIV - 1));
    assign unused_bits = ^{bus.read, bus.wr_data[31:16]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Channels see the enable mask as it will be after this edge, so a disable
    // darkens the LED on the write edge and a 0->1 enable restarts the count.
    always_comb begin
        en_next   = en_mask;
        period_wr = '0;
        if (wr_en && bus.addr == ADDR_CTRL) begin
            en_next = bus.wr_data[N_LED-1:0];
        end
        for (int i = 0; i < N_LED; i++) begin
            if (wr_en && bus.addr == ADDR_PERIOD0 + 5'(i)) begin
                period_wr[i] = 1'b1;
            end
        end
        load = period_wr | (en_next & ~en_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_mask <= '0;
            for (int i = 0; i < N_LED; i++) begin
                period[i] <= '0;
            end
        end else begin
            en_mask <= en_next;
            for (int i = 0; i < N_LED; i++) begin
                if (period_wr[i]) begin
                    period[i] <= bus.wr_data[15:0];
                end
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (bus.addr == ADDR_CTRL) begin
            bus.rd_data[N_LED-1:0] = en_mask;
        end else if (bus.addr == ADDR_STATUS) begin
            bus.rd_data[2*N_LED-1:0] = {en_mask, led};
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                if (bus.addr == ADDR_PERIOD0 + 5'(i)) begin
                    bus.rd_data[15:0] = period[i];
                end
            end
        end
    end

    for (genvar g = 0; g < N_LED; g++) begin : g_ch
        blink_channel u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .en     (en_next[g]),
            .period (period[g]),
            .load   (load[g]),
            .led    (led[g])
        );
    end

endmodule
